// File: rtl/bpu_bht_btb_if.sv
// Fetch/decode-side bundle for the branch prediction unit: IF lookup, ID training,
// ID recovery and performance counter readout.
interface bpu_bht_btb_if #(
  parameter int unsigned GHR_W  = 6,
  parameter int unsigned PERF_W = 32
) ();

  // IF-stage lookup
  logic [31:0]       PC_F;
  logic              pred_jump_F;
  logic [31:0]       pred_target;
  logic [GHR_W-1:0]  pred_ghr_F;

  // ID-stage resolution and training
  logic              stall_D;
  logic              upd_valid_D;
  logic [31:0]       PC_D;
  logic              PC_src_D;
  logic [31:0]       real_target;
  logic              pred_jump_D;
  logic [31:0]       pred_target_D;
  logic [GHR_W-1:0]  upd_ghr_D;
  logic              mispredict_D;
  logic [31:0]       recover_pc_D;

  // Performance counters
  logic [PERF_W-1:0] branch_cnt;
  logic [PERF_W-1:0] mispred_cnt;

  // Core side: drives PCs and resolution, consumes predictions.
  modport master (
    output PC_F, stall_D, upd_valid_D, PC_D, PC_src_D, real_target,
           pred_jump_D, pred_target_D, upd_ghr_D,
    input  pred_jump_F, pred_target, pred_ghr_F, mispredict_D, recover_pc_D,
           branch_cnt, mispred_cnt
  );

  // Predictor side.
  modport slave (
    input  PC_F, stall_D, upd_valid_D, PC_D, PC_src_D, real_target,
           pred_jump_D, pred_target_D, upd_ghr_D,
    output pred_jump_F, pred_target, pred_ghr_F, mispredict_D, recover_pc_D,
           branch_cnt, mispred_cnt
  );

endinterface

// File: rtl/bpu_bht_btb.sv
// Direct-mapped BTB plus saturating-counter BHT with bimodal or gshare indexing.
// Combinational lookup on the IF PC, non-speculative training from the ID stage.
module bpu_bht_btb #(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned GSHARE  = 0,
  parameter int unsigned GHR_W   = 6,
  parameter int unsigned PERF_W  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  bpu_bht_btb_if.slave    bp
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'((2 ** (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_MIN  = '0;
  localparam logic [PERF_W-1:0] PERF_MAX = '1;

  // Prediction state
  logic [ENTRIES-1:0] btb_valid_q;
  logic [TAG_W-1:0]   btb_tag_q [ENTRIES];
  logic [31:0]        btb_tgt_q [ENTRIES];
  logic [CNT_W-1:0]   bht_q     [ENTRIES];
  logic [GHR_W-1:0]   ghr_q, ghr_d;
  logic [PERF_W-1:0]  branch_cnt_q, branch_cnt_d;
  logic [PERF_W-1:0]  mispred_cnt_q, mispred_cnt_d;

  // IF-side lookup signals
  logic [IDX_W-1:0]   f_idx_pc;
  logic [TAG_W-1:0]   f_tag;
  logic [IDX_W-1:0]   f_bht_idx;
  logic               f_hit;
  logic               f_taken;

  // ID-side training signals
  logic [IDX_W-1:0]   d_idx_pc;
  logic [TAG_W-1:0]   d_tag;
  logic [IDX_W-1:0]   d_bht_idx;
  logic [CNT_W-1:0]   d_cnt_cur;
  logic [CNT_W-1:0]   d_cnt_nxt;
  logic               train;
  logic               mispredict;

  // Field extraction; the BTB is always indexed by PC alone.
  assign f_idx_pc = bp.PC_F[IDX_W+1:2];
  assign f_tag    = bp.PC_F[IDX_W+1+TAG_W:IDX_W+2];
  assign d_idx_pc = bp.PC_D[IDX_W+1:2];
  assign d_tag    = bp.PC_D[IDX_W+1+TAG_W:IDX_W+2];

  // Lookup hashes with the live GHR, training with the snapshot taken at lookup.
  assign f_bht_idx = (GSHARE != 0) ? (f_idx_pc ^ IDX_W'(ghr_q))        : f_idx_pc;
  assign d_bht_idx = (GSHARE != 0) ? (d_idx_pc ^ IDX_W'(bp.upd_ghr_D)) : d_idx_pc;

  always_comb begin : lookup
    f_hit   = 1'b0;
    f_taken = 1'b0;
    f_hit   = btb_valid_q[f_idx_pc] && (btb_tag_q[f_idx_pc] == f_tag);
    f_taken = f_hit && bht_q[f_bht_idx][CNT_W-1];
  end

  assign bp.pred_jump_F = f_taken;
  assign bp.pred_target = f_taken ? btb_tgt_q[f_idx_pc] : (bp.PC_F + 32'd4);
  assign bp.pred_ghr_F  = ghr_q;

  // Resolution: a taken branch is also wrong if it went somewhere else.
  assign train      = bp.upd_valid_D && !bp.stall_D;
  assign mispredict = bp.upd_valid_D &&
                      ((bp.pred_jump_D != bp.PC_src_D) ||
                       (bp.PC_src_D && (bp.pred_target_D != bp.real_target)));

  assign bp.mispredict_D = mispredict;
  assign bp.recover_pc_D = bp.PC_src_D ? bp.real_target : (bp.PC_D + 32'd4);

  always_comb begin : cnt_next
    d_cnt_cur = bht_q[d_bht_idx];
    d_cnt_nxt = d_cnt_cur;
    if (bp.PC_src_D) begin
      if (d_cnt_cur != CNT_MAX) d_cnt_nxt = d_cnt_cur + CNT_W'(1);
    end else begin
      if (d_cnt_cur != CNT_MIN) d_cnt_nxt = d_cnt_cur - CNT_W'(1);
    end
  end

  always_comb begin : misc_next
    ghr_d         = ghr_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (train) begin
      if (GSHARE != 0)                 ghr_d         = GHR_W'({ghr_q, bp.PC_src_D});
      if (branch_cnt_q != PERF_MAX)    branch_cnt_d  = branch_cnt_q + PERF_W'(1);
      if (mispredict && (mispred_cnt_q != PERF_MAX))
                                       mispred_cnt_d = mispred_cnt_q + PERF_W'(1);
    end
  end

  // Reset-bearing state: valid bits, counters, history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btb_valid_q   <= '0;
      ghr_q         <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) bht_q[i] <= CNT_INIT;
    end else begin
      ghr_q         <= ghr_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      if (train) begin
        bht_q[d_bht_idx] <= d_cnt_nxt;
        if (bp.PC_src_D) btb_valid_q[d_idx_pc] <= 1'b1;
      end
    end
  end

  // Tag/target payload is only meaningful behind a valid bit, so it carries no reset.
  always_ff @(posedge clk) begin
    if (train && bp.PC_src_D) begin
      btb_tag_q[d_idx_pc] <= d_tag;
      btb_tgt_q[d_idx_pc] <= bp.real_target;
    end
  end

  assign bp.branch_cnt  = branch_cnt_q;
  assign bp.mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_bpu_bht_btb.sv
// Directed bench: a bimodal instance (defaults) and a gshare instance (GHR_W=2, PERF_W=4).
module tb_bpu_bht_btb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bpu_bht_btb_if #(.GHR_W(6), .PERF_W(32)) bim_if ();
  bpu_bht_btb_if #(.GHR_W(2), .PERF_W(4))  gsh_if ();

  bpu_bht_btb #(.ENTRIES(64), .TAG_W(8), .CNT_W(2), .GSHARE(0), .GHR_W(6), .PERF_W(32))
    u_bim (.clk(clk), .rst_n(rst_n), .bp(bim_if));

  bpu_bht_btb #(.ENTRIES(64), .TAG_W(8), .CNT_W(2), .GSHARE(1), .GHR_W(2), .PERF_W(4))
    u_gsh (.clk(clk), .rst_n(rst_n), .bp(gsh_if));

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        valid;
    logic        pj;
    logic [31:0] pt;
    logic        src;
    logic [31:0] rt;
    logic [31:0] pc;
    logic        exp_mis;
    logic [31:0] exp_rec;
  } vec_t;

  vec_t vecs [8];
  logic exp_p   [8];
  logic [1:0] exp_ghr [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic look_b(input logic [31:0] pc, input logic ej, input logic [31:0] et,
                        input string name);
    bim_if.PC_F = pc;
    #1;
    chk({name, "_jump"},   32'(bim_if.pred_jump_F), 32'(ej));
    chk({name, "_target"}, bim_if.pred_target, et);
  endtask

  task automatic train_b(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic pj, input logic [31:0] pt);
    bim_if.PC_D          = pc;
    bim_if.PC_src_D      = tk;
    bim_if.real_target   = tgt;
    bim_if.pred_jump_D   = pj;
    bim_if.pred_target_D = pt;
    bim_if.stall_D       = 1'b0;
    bim_if.upd_valid_D   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bim_if.upd_valid_D   = 1'b0;
  endtask

  task automatic train_g(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic pj, input logic [31:0] pt, input logic [1:0] ghr);
    gsh_if.PC_D          = pc;
    gsh_if.PC_src_D      = tk;
    gsh_if.real_target   = tgt;
    gsh_if.pred_jump_D   = pj;
    gsh_if.pred_target_D = pt;
    gsh_if.upd_ghr_D     = ghr;
    gsh_if.stall_D       = 1'b0;
    gsh_if.upd_valid_D   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    gsh_if.upd_valid_D   = 1'b0;
  endtask

  initial begin
    // valid, pj, pt, src, rt, PC_D, exp mispredict, exp recover
    vecs[0] = '{1'b1, 1'b1, 32'h300, 1'b1, 32'h340, 32'h2FC,     1'b1, 32'h340};
    vecs[1] = '{1'b1, 1'b1, 32'h300, 1'b0, 32'h340, 32'h2FC,     1'b1, 32'h300};
    vecs[2] = '{1'b1, 1'b1, 32'h340, 1'b1, 32'h340, 32'h2FC,     1'b0, 32'h340};
    vecs[3] = '{1'b1, 1'b0, 32'h000, 1'b0, 32'h000, 32'h500,     1'b0, 32'h504};
    vecs[4] = '{1'b1, 1'b0, 32'h000, 1'b1, 32'h800, 32'h600,     1'b1, 32'h800};
    vecs[5] = '{1'b0, 1'b1, 32'h300, 1'b0, 32'h000, 32'h010,     1'b0, 32'h014};
    vecs[6] = '{1'b1, 1'b0, 32'h123, 1'b0, 32'h999, 32'hFFFFFFFC, 1'b0, 32'h0};
    vecs[7] = '{1'b1, 1'b1, 32'h340, 1'b1, 32'h344, 32'h2FC,     1'b1, 32'h344};

    // Gshare T/N alternation at 0x400, hand-traced from GHR=00 and counters at 01
    exp_p   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_ghr = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1};

    bim_if.PC_F = 32'h0;  bim_if.stall_D = 1'b0; bim_if.upd_valid_D = 1'b0;
    bim_if.PC_D = 32'h0;  bim_if.PC_src_D = 1'b0; bim_if.real_target = 32'h0;
    bim_if.pred_jump_D = 1'b0; bim_if.pred_target_D = 32'h0; bim_if.upd_ghr_D = '0;
    gsh_if.PC_F = 32'h0;  gsh_if.stall_D = 1'b0; gsh_if.upd_valid_D = 1'b0;
    gsh_if.PC_D = 32'h0;  gsh_if.PC_src_D = 1'b0; gsh_if.real_target = 32'h0;
    gsh_if.pred_jump_D = 1'b0; gsh_if.pred_target_D = 32'h0; gsh_if.upd_ghr_D = '0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    look_b(32'h100, 1'b0, 32'h104, "rst_lookup");
    chk("rst_branch_cnt",  bim_if.branch_cnt,  32'h0);
    chk("rst_mispred_cnt", bim_if.mispred_cnt, 32'h0);
    chk("rst_ghr_gsh",     32'(gsh_if.pred_ghr_F), 32'h0);

    // Combinational resolution vectors, held in stall so nothing trains
    bim_if.stall_D = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bim_if.upd_valid_D   = vecs[i].valid;
      bim_if.pred_jump_D   = vecs[i].pj;
      bim_if.pred_target_D = vecs[i].pt;
      bim_if.PC_src_D      = vecs[i].src;
      bim_if.real_target   = vecs[i].rt;
      bim_if.PC_D          = vecs[i].pc;
      #1;
      chk($sformatf("vec%0d_mispredict", i), 32'(bim_if.mispredict_D), 32'(vecs[i].exp_mis));
      chk($sformatf("vec%0d_recover", i),    bim_if.recover_pc_D, vecs[i].exp_rec);
    end
    @(posedge clk);
    @(negedge clk);
    bim_if.upd_valid_D = 1'b0;
    bim_if.stall_D     = 1'b0;
    chk("vec_stalled_branch_cnt", bim_if.branch_cnt, 32'h0);

    // Lookup during the training cycle sees the old (empty) entry
    bim_if.PC_F          = 32'h200;
    bim_if.PC_D          = 32'h200;
    bim_if.PC_src_D      = 1'b1;
    bim_if.real_target   = 32'h180;
    bim_if.pred_jump_D   = 1'b0;
    bim_if.pred_target_D = 32'h0;
    bim_if.upd_valid_D   = 1'b1;
    #1;
    chk("same_cycle_jump",   32'(bim_if.pred_jump_F), 32'h0);
    chk("same_cycle_target", bim_if.pred_target, 32'h204);
    @(posedge clk);
    @(negedge clk);
    bim_if.upd_valid_D = 1'b0;
    look_b(32'h200, 1'b1, 32'h180, "t1");

    train_b(32'h200, 1'b1, 32'h180, 1'b1, 32'h180);
    look_b(32'h200, 1'b1, 32'h180, "t2");
    chk("t2_branch_cnt",  bim_if.branch_cnt,  32'd2);
    chk("t2_mispred_cnt", bim_if.mispred_cnt, 32'd1);

    train_b(32'h200, 1'b0, 32'h0, 1'b1, 32'h180);
    look_b(32'h200, 1'b1, 32'h180, "nt1");
    train_b(32'h200, 1'b0, 32'h0, 1'b1, 32'h180);
    look_b(32'h200, 1'b0, 32'h204, "nt2");
    chk("nt2_branch_cnt",  bim_if.branch_cnt,  32'd4);
    chk("nt2_mispred_cnt", bim_if.mispred_cnt, 32'd3);

    // Alias 0x300 shares index 0 with 0x200 but has a different tag
    train_b(32'h200, 1'b1, 32'h180, 1'b0, 32'h0);
    train_b(32'h200, 1'b1, 32'h180, 1'b1, 32'h180);
    look_b(32'h300, 1'b0, 32'h304, "alias_miss");
    look_b(32'h200, 1'b1, 32'h180, "alias_orig");
    train_b(32'h300, 1'b1, 32'h3C0, 1'b0, 32'h0);
    look_b(32'h300, 1'b1, 32'h3C0, "alias_new");
    look_b(32'h200, 1'b0, 32'h204, "alias_evict");
    chk("alias_branch_cnt",  bim_if.branch_cnt,  32'd7);
    chk("alias_mispred_cnt", bim_if.mispred_cnt, 32'd5);

    // Stall held three cycles, then released for one: exactly one training event
    bim_if.PC_D          = 32'h300;
    bim_if.PC_src_D      = 1'b0;
    bim_if.real_target   = 32'h0;
    bim_if.pred_jump_D   = 1'b1;
    bim_if.pred_target_D = 32'h3C0;
    bim_if.upd_valid_D   = 1'b1;
    bim_if.stall_D       = 1'b1;
    #1;
    chk("stall_mispredict", 32'(bim_if.mispredict_D), 32'h1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("stall%0d_branch_cnt", c), bim_if.branch_cnt, 32'd7);
    end
    bim_if.stall_D = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bim_if.upd_valid_D = 1'b0;
    chk("unstall_branch_cnt",  bim_if.branch_cnt,  32'd8);
    chk("unstall_mispred_cnt", bim_if.mispred_cnt, 32'd6);
    look_b(32'h300, 1'b1, 32'h3C0, "stall_one_step");
    train_b(32'h300, 1'b0, 32'h0, 1'b1, 32'h3C0);
    look_b(32'h300, 1'b0, 32'h304, "stall_next_step");

    // Asynchronous reset mid-cycle clears state at once
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_branch_cnt",  bim_if.branch_cnt,  32'h0);
    chk("midrst_mispred_cnt", bim_if.mispred_cnt, 32'h0);
    look_b(32'h300, 1'b0, 32'h304, "midrst_lookup");
    @(negedge clk);
    rst_n = 1'b1;

    // Gshare alternating pattern
    for (int i = 0; i < 8; i++) begin
      logic tk;
      logic [31:0] et;
      tk = (i % 2 == 0);
      et = exp_p[i] ? 32'h480 : 32'h404;
      gsh_if.PC_F = 32'h400;
      #1;
      chk($sformatf("gsh%0d_jump", i),   32'(gsh_if.pred_jump_F), 32'(exp_p[i]));
      chk($sformatf("gsh%0d_ghr", i),    32'(gsh_if.pred_ghr_F),  32'(exp_ghr[i]));
      chk($sformatf("gsh%0d_target", i), gsh_if.pred_target, et);
      train_g(32'h400, tk, 32'h480, exp_p[i], exp_p[i] ? 32'h480 : 32'h0, exp_ghr[i]);
    end
    chk("gsh_branch_cnt",  32'(gsh_if.branch_cnt),  32'd8);
    chk("gsh_mispred_cnt", 32'(gsh_if.mispred_cnt), 32'd2);

    // 4-bit performance counters saturate at 0xF
    for (int k = 0; k < 20; k++) begin
      train_g(32'h800, 1'b0, 32'h0, 1'b1, 32'h804, 2'd0);
      if (k == 6) begin
        chk("sat_mid_branch_cnt",  32'(gsh_if.branch_cnt),  32'hF);
        chk("sat_mid_mispred_cnt", 32'(gsh_if.mispred_cnt), 32'd9);
      end
    end
    chk("sat_branch_cnt",  32'(gsh_if.branch_cnt),  32'hF);
    chk("sat_mispred_cnt", 32'(gsh_if.mispred_cnt), 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bpu_bht_btb.md
# bpu_bht_btb

Parametrised branch prediction unit for the 5-stage core: a direct-mapped BTB (tag + target) plus a table of saturating counters (BHT), with selectable bimodal or gshare indexing. Lookup is combinational on the IF-stage PC. Training happens from the ID stage, where branches and jumps resolve. It also produces the ID-stage mispredict/recovery signals and saturating performance counters, replacing the always-not-taken PC+4 path in front of the PC register.

## Interface
- ENTRIES, 64: BTB/BHT entry count; power of two, ≥ 4; IDX_W = log2(ENTRIES).
- TAG_W, 8: BTB tag width; IDX_W+2+TAG_W ≤ 32.
- CNT_W, 2: BHT counter width, 1..4.
- GSHARE, 0: 0 = bimodal index, 1 = gshare index.
- GHR_W, 6: global history width, 1..IDX_W; ignored when GSHARE=0.
- PERF_W, 32: performance counter width.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- PC_F  in  32  fetch PC.
- pred_jump_F  out  1  predicted taken.
- pred_target  out  32  predicted next PC (target if taken, else PC_F+4).
- pred_ghr_F  out  GHR_W  GHR snapshot at lookup; carried through IF_ID.
- stall_D  in  1  ID stage stalled; blocks training.
- upd_valid_D  in  1  ID holds a resolved branch/jump (not a bubble).
- PC_D  in  32  PC of the resolved instruction.
- PC_src_D  in  1  actual taken.
- real_target  in  32  actual target (valid when taken).
- pred_jump_D  in  1  prediction made for this instruction, pipelined from IF.
- pred_target_D  in  32  predicted target, pipelined.
- upd_ghr_D  in  GHR_W  pred_ghr_F, pipelined.
- mispredict_D  out  1  prediction wrong; flush IF_ID and redirect.
- recover_pc_D  out  32  correct next PC.
- branch_cnt  out  PERF_W  trained branches.
- mispred_cnt  out  PERF_W  mispredictions.

## Operation
- Fields: idx_pc = pc[IDX_W+1:2]; tag = pc[IDX_W+1+TAG_W:IDX_W+2].
- BHT index:
  - Bimodal: idx_pc.
  - Gshare: idx_pc XOR zero-extended GHR. Lookup uses the current GHR; training uses upd_ghr_D.
- BTB index: always idx_pc.
- Lookup (combinational):
  - hit = btb_valid[idx] && tag match.
  - pred_jump_F = hit && MSB of the BHT counter.
  - pred_target = pred_jump_F ? btb_target[idx] : PC_F+4 (mod 2^32).
- Training enable: train = upd_valid_D && !stall_D. All updates below happen on the rising edge only when train=1.
- BHT counter update: saturating. Increment if PC_src_D (cap at 2^CNT_W−1); decrement if not (floor at 0).
- BTB update:
  - If PC_src_D: write valid=1, tag, target=real_target, overwriting any alias.
  - If not taken: no allocation; an existing entry is kept.
- GHR update (GSHARE=1 only): shifts left with PC_src_D inserted at bit 0 (non-speculative).
- mispredict_D = upd_valid_D && ((pred_jump_D != PC_src_D) || (PC_src_D && pred_target_D != real_target)). Combinational; it is not gated by stall_D.
- recover_pc_D = PC_src_D ? real_target : PC_D+4.
- Performance counters:
  - branch_cnt increments on train.
  - mispred_cnt increments on train && mispredict_D.
  - Both saturate at all-ones.

## Timing
- Reset (asynchronous) sets:
  - All btb_valid to 0; BTB tag/target arrays need no reset.
  - Every BHT counter to weakly-not-taken, 2^(CNT_W−1)−1 (01 for CNT_W=2; 0 for CNT_W=1).
  - GHR and both performance counters to 0.
- Reset output values: pred_jump_F=0, pred_target=PC_F+4, pred_ghr_F=0. mispredict_D and recover_pc_D follow their inputs combinationally.
- Lookup latency 0: pred_* valid in the same cycle as PC_F.
- Training takes effect at the next edge. A lookup in the update cycle sees the old contents (no write bypass).
- Simultaneous lookup and train to the same index are legal: the lookup returns pre-update data and the write completes.
- stall_D held for N cycles produces exactly one training event, in the cycle stall_D drops.
- Reset asserted mid-operation clears state immediately. There is no partial update on the edge coincident with reset release.

## Test plan
- Reset, then PC_F=0x100 → pred_jump_F=0 and pred_target=0x104. Counters read 0.
- Bimodal, CNT_W=2: train PC 0x200 taken to 0x180 twice → lookup 0x200 gives pred_jump_F=1 and pred_target=0x180. One not-taken → still 1. Second not-taken → 0.
- Alias: after training 0x200, lookup 0x200+4·ENTRIES (same index, different tag) → pred_jump_F=0. Training the alias taken replaces the entry, so 0x200 now misses.
- Mispredict: pred_jump_D=1, pred_target_D=0x300, PC_src_D=1, real_target=0x340 → mispredict_D=1, recover_pc_D=0x340. With PC_src_D=0 and PC_D=0x2FC → recover_pc_D=0x300.
- Stall gating: upd_valid_D=1 with stall_D=1 for 3 cycles, then 0 → branch_cnt increments by exactly 1 and the counter moves one step.
- Gshare, GHR_W=2: alternating T/N branch at 0x400 trained 8 times → prediction matches the pattern every iteration after warm-up. Saturation: preload branch_cnt near all-ones (PERF_W=4) → holds at 0xF.
